// File: rtl/mux_demux_pkg.sv
// Shared definitions for the 32x8 serializer and the 8x32 deserializer.
// Word/byte geometry, counter width and an MSB-first byte selector.
package mux_demux_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int CNT_W  = $clog2(NBYTES);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t LAST_IDX = cnt_t'(NBYTES - 1);

  // Slice k counted from the MSB end: k=0 is the top byte of the word.
  function automatic byte_t byte_sel(input word_t w, input cnt_t k);
    int idx;
    idx = int'(k);
    return w[WORD_W-1-BYTE_W*idx -: BYTE_W];
  endfunction

endpackage

// File: rtl/mux_32x8.sv
// Word-to-byte serializer. One active word is shifted out MSB byte first,
// one byte per clk_4f cycle; a second pending word is buffered so that a
// continuous word stream leaves with no bubble between words.
module mux_32x8
  import mux_demux_pkg::*;
(
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic [WORD_W-1:0] data_in_32x8,
  input  logic              valid_in_32x8,
  output logic              ready_out_32x8,
  output logic [BYTE_W-1:0] data_out_32x8,
  output logic              valid_out_32x8
);

  word_t r_active;
  word_t r_pending;
  logic  r_active_valid;
  logic  r_pending_valid;
  cnt_t  r_cnt;

  logic  w_accept;
  logic  w_src_valid;
  word_t w_src;
  logic  w_last;
  logic  w_load;

  // Ready depends only on the pending slot, never on valid_in, so the
  // upstream handshake has no combinational loop through this block.
  assign ready_out_32x8 = reset_L & ~r_pending_valid;
  assign w_accept       = valid_in_32x8 & ready_out_32x8;

  // The pending word always wins over the input so words leave in order.
  assign w_src_valid = r_pending_valid | w_accept;
  assign w_src       = r_pending_valid ? r_pending : data_in_32x8;
  assign w_last      = (r_cnt == LAST_IDX);

  // A new word enters the active register when idle or on the last byte.
  assign w_load = w_src_valid & (~r_active_valid | w_last);

  // Active word, byte counter, pending slot and registered outputs.
  // NOTE: the word registers are reset along with the control flops so the
  // whole process shares a single async-reset template; a flop left out of
  // the reset branch in this block would pick up an unwanted hold enable.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_active        <= '0;
      r_pending       <= '0;
      r_active_valid  <= 1'b0;
      r_pending_valid <= 1'b0;
      r_cnt           <= '0;
      data_out_32x8   <= '0;
      valid_out_32x8  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge value of each flop regardless of statement order.
      if (r_active_valid) begin
        data_out_32x8  <= byte_sel(r_active, r_cnt);
        valid_out_32x8 <= 1'b1;
        if (!w_last) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (w_src_valid) begin
          r_active <= w_src;
          r_cnt    <= '0;
        end else begin
          r_cnt          <= '0;
          r_active_valid <= 1'b0;
        end
      end else if (w_src_valid) begin
        // Idle start: byte 0 goes out on this same edge.
        data_out_32x8  <= byte_sel(w_src, '0);
        valid_out_32x8 <= 1'b1;
        r_active       <= w_src;
        r_cnt          <= cnt_t'(1);
        r_active_valid <= 1'b1;
      end else begin
        data_out_32x8  <= '0;
        valid_out_32x8 <= 1'b0;
      end

      // Pending drains when it feeds the active register; an accepted word
      // that does not go straight to active parks here.
      if (w_load && r_pending_valid) begin
        r_pending_valid <= 1'b0;
      end else if (w_accept && !w_load) begin
        r_pending       <= data_in_32x8;
        r_pending_valid <= 1'b1;
      end
    end
  end

endmodule
